// File: rtl/wfi_sleep_ctrl_pkg.sv
// Shared types and configuration for the WFI sleep sequencer.
package wfi_sleep_ctrl_pkg;

  typedef enum logic [2:0] {
    Idle,
    Drain,
    Sleep,
    Gated,
    Wake
  } wfistate_t;

  localparam logic [1:0] PRIV_M = 2'b11;

  typedef struct packed {
    int unsigned WFI_TIMEOUT_BITS;
    int unsigned WFI_GATE_DELAY;
  } cvw_t;

  localparam cvw_t WFI_DEFAULT_CFG = '{WFI_TIMEOUT_BITS: 16, WFI_GATE_DELAY: 4};

endpackage

// File: rtl/wfi_sleep_ctrl_if.sv
// Pipeline-side signal bundle for the WFI sleep sequencer.
interface wfi_sleep_ctrl_if #(
  parameter int unsigned TIMEOUT_BITS = 16
) ();

  logic                    wfiM;
  logic                    InstrValidM;
  logic                    TrapM;
  logic                    IntPendingM;
  logic                    CommittedM;
  logic                    STATUS_TW;
  logic [1:0]              PrivilegeModeW;
  logic                    WFIStallM;
  logic                    WFITimeoutM;
  logic                    SleepReq;
  logic [TIMEOUT_BITS-1:0] SleepCount;

  // Pipeline / privileged-unit side
  modport master (
    output wfiM, InstrValidM, TrapM, IntPendingM, CommittedM, STATUS_TW, PrivilegeModeW,
    input  WFIStallM, WFITimeoutM, SleepReq, SleepCount
  );

  // Sequencer side
  modport slave (
    input  wfiM, InstrValidM, TrapM, IntPendingM, CommittedM, STATUS_TW, PrivilegeModeW,
    output WFIStallM, WFITimeoutM, SleepReq, SleepCount
  );

endinterface

// File: rtl/wfi_sleep_ctrl_timer.sv
// Saturating sleep-cycle counter with clear priority over enable.
module wfi_timer #(
  parameter int unsigned Width     = 16,
  parameter int unsigned GateDelay = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [Width-1:0] count_o,
  output logic             at_limit_o,
  output logic             at_gate_o
);

  localparam logic [Width-1:0] GateCount = Width'(GateDelay - 1);

  logic [Width-1:0] count_q, count_d;

  assign at_limit_o = &count_q;
  assign at_gate_o  = (count_q == GateCount);
  assign count_o    = count_q;

  // Next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !at_limit_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wfi_sleep_ctrl.sv
// WFI sequencer: stall, drain committed traffic, sleep, gate clock or time out, wake.
module wfi_sleep_ctrl
  import wfi_sleep_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_BITS = WFI_DEFAULT_CFG.WFI_TIMEOUT_BITS,
  parameter int unsigned GATE_DELAY   = WFI_DEFAULT_CFG.WFI_GATE_DELAY
) (
  input logic             clk,
  input logic             reset_n,
  wfi_sleep_ctrl_if.slave bus
);

  wfistate_t state_q, state_d;

  logic                    tw_active;
  logic                    start;
  logic                    in_sleep;
  logic                    timeout_hit;
  logic                    sleep_req_q;
  logic                    timer_clear;
  logic                    timer_enable;
  logic [TIMEOUT_BITS-1:0] count;
  logic                    at_limit;
  logic                    at_gate;

  assign tw_active    = bus.STATUS_TW & (bus.PrivilegeModeW != PRIV_M);
  // Gated by reset so the same-cycle stall cannot leak out while held in reset
  assign start        = bus.wfiM & bus.InstrValidM & ~bus.TrapM & reset_n;
  assign in_sleep     = (state_q == Sleep) | (state_q == Gated);
  // Trap and interrupt both outrank the timeout
  assign timeout_hit  = in_sleep & tw_active & at_limit & ~bus.IntPendingM & ~bus.TrapM;
  assign timer_enable = in_sleep;

  wfi_timer #(
    .Width     (TIMEOUT_BITS),
    .GateDelay (GATE_DELAY)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (timer_clear),
    .enable_i   (timer_enable),
    .count_o    (count),
    .at_limit_o (at_limit),
    .at_gate_o  (at_gate)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter-clear decode
  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    unique case (state_q)
      Idle: begin
        if (start && !bus.IntPendingM) state_d = Drain;
      end
      Drain: begin
        if (bus.TrapM) begin
          state_d     = Idle;
          timer_clear = 1'b1;
        end else if (bus.IntPendingM) begin
          state_d = Wake;
        end else if (!bus.CommittedM) begin
          state_d     = Sleep;
          timer_clear = 1'b1;
        end
      end
      Sleep, Gated: begin
        if (bus.TrapM) begin
          state_d     = Idle;
          timer_clear = 1'b1;
        end else if (bus.IntPendingM) begin
          state_d = Wake;
        end else if (timeout_hit) begin
          state_d = Idle;
        end else if ((state_q == Sleep) && at_gate) begin
          state_d = Gated;
        end
      end
      Wake: begin
        state_d     = Idle;
        timer_clear = bus.TrapM;
      end
      default: state_d = Idle;
    endcase
  end

  // Stall and timeout outputs
  always_comb begin
    bus.WFIStallM   = 1'b0;
    bus.WFITimeoutM = 1'b0;
    unique case (state_q)
      Idle:         bus.WFIStallM = start & ~bus.IntPendingM;
      Drain, Wake:  bus.WFIStallM = 1'b1;
      Sleep, Gated: begin
        bus.WFIStallM   = ~timeout_hit;
        bus.WFITimeoutM = timeout_hit;
      end
      default: ;
    endcase
  end

  // Clock-gate request is registered so it is glitch-free toward the SoC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sleep_req_q <= 1'b0;
    end else begin
      sleep_req_q <= (state_d == Gated);
    end
  end

  assign bus.SleepReq   = sleep_req_q;
  assign bus.SleepCount = count;

endmodule

// File: doc/wfi_sleep_ctrl.md
Name: wfi_sleep_ctrl

Overview:
Sequences execution of the WFI instruction in the Memory stage. The block stalls the pipeline, waits for committed bus traffic to drain, and counts sleep cycles. It then either raises a clock-gate request or enforces the mstatus.TW timeout, and releases the pipeline when an enabled interrupt becomes pending. It sits beside the privileged unit: privilege-decode supplies wfiM, trap logic supplies IntPendingM and TrapM, and WFITimeoutM feeds trap logic as an illegal-instruction source.

Parameters:
TIMEOUT_BITS, 16, width of sleep counter; timeout limit = 2^TIMEOUT_BITS-1 cycles
GATE_DELAY, 4, SLEEP cycles before SleepReq asserts (1 <= GATE_DELAY < limit)

Ports:
clk  in  1  core clock (ungated; block never sleeps itself)
reset_n  in  1  asynchronous active-low reset
wfiM  in  1  WFI decoded in Memory stage
InstrValidM  in  1  Memory-stage instruction valid
TrapM  in  1  trap/interrupt taken this cycle
IntPendingM  in  1  any interrupt pending and enabled in mie, ignoring global enables
CommittedM  in  1  Memory stage holds a committed bus transaction
STATUS_TW  in  1  timeout-wait bit
PrivilegeModeW  in  2  current privilege mode (2'b11 = M)
WFIStallM  out  1  stall request to hazard unit
WFITimeoutM  out  1  one-cycle TW timeout fault to trap logic
SleepReq  out  1  clock-gate request to SoC
SleepCount  out  TIMEOUT_BITS  current counter value (perf/debug)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0; all outputs 0. Reset during any state aborts immediately. No pending WFI survives reset.
- TWActive = STATUS_TW & (PrivilegeModeW != 2'b11).
- Start = wfiM & InstrValidM & ~TrapM.
- IDLE:
  - Start & IntPendingM: WFI retires as NOP; no stall; stay IDLE.
  - Start & ~IntPendingM: WFIStallM=1 combinationally in the same cycle; next state DRAIN.
- DRAIN: WFIStallM=1.
  - ~CommittedM: go to SLEEP, counter<=0.
  - IntPendingM has priority over the drain: go to WAKE.
- SLEEP: WFIStallM=1; counter increments each cycle, saturating at the all-ones limit. Priority order:
  1. IntPendingM: go to WAKE.
  2. TWActive & counter==limit: WFITimeoutM=1 this cycle, WFIStallM=0; go to IDLE.
  3. counter==GATE_DELAY-1: go to GATED.
- GATED: WFIStallM=1, SleepReq=1 (registered, asserted from the first GATED cycle). Counter keeps counting. Same priority order as SLEEP for 1 and 2.
- WAKE: one cycle. WFIStallM=1, SleepReq=0, so the gate reopens before the pipeline resumes. Next state IDLE; WFIStallM falls the following cycle. On re-evaluation in IDLE, the WFI still in M sees IntPendingM=1 and retires or traps normally.
- TrapM=1 in any non-IDLE state: go to IDLE next cycle and clear the counter. Interrupt or flush wins over sleep.
- IntPendingM and timeout in the same cycle: the interrupt wins; WFITimeoutM=0.
- TW toggled or privilege changed mid-sleep: TWActive is re-evaluated every cycle. If counter is already at the limit when TWActive rises, timeout fires in that cycle.
- TWActive=0: no timeout; sleep is unbounded until an interrupt arrives.
- SleepCount = counter in all states; it holds its value in IDLE until the next DRAIN→SLEEP transition clears it.

Decomposition:
- Shared cvw package: enum wfistate_t {IDLE, DRAIN, SLEEP, GATED, WAKE} and localparam PRIV_M=2'b11. Add TIMEOUT_BITS and GATE_DELAY as cvw_t fields WFI_TIMEOUT_BITS and WFI_GATE_DELAY.
- One sub-module: wfi_timer, a clear/enable saturating counter that outputs the count plus AtLimit and AtGate flags.
- The FSM stays in wfi_sleep_ctrl.

Test Plan:
- WFI (wfiM=InstrValidM=1) with IntPendingM=1 → WFIStallM never asserts; state stays IDLE.
- WFI, CommittedM high for 3 cycles, no interrupt, TW=0 → DRAIN for 3 cycles, SLEEP. SleepReq=1 after 4 SLEEP cycles (GATE_DELAY=4). IntPendingM raised in cycle 20 → WAKE next cycle, SleepReq=0, WFIStallM=0 one cycle later.
- U-mode, TW=1, TIMEOUT_BITS=4 → WFITimeoutM pulses exactly once, when SleepCount=15; WFIStallM=0 that cycle; state returns to IDLE.
- M-mode, TW=1, no interrupt for 100 cycles → no timeout; SleepCount saturates at 15; SleepReq stays 1.
- IntPendingM and the timeout condition in the same cycle → WFITimeoutM=0; WAKE taken.
- reset_n pulled low while in GATED → SleepReq, WFIStallM and SleepCount are 0 asynchronously; FSM is in IDLE after release.
